// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/size/response encodings, the slave
// state enum and the byte-lane decode used by the SRAM responder.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slv_state_e;

  // Little-endian lane enables; odd halfword addresses fall to the aligned
  // half and anything wider than a halfword covers the whole word.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << lane;
      HSIZE_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default:    byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// DEPTH x 32-bit word storage with per-byte write enables and an
// asynchronous read port. Contents are not reset.
//   clk_i   : write clock
//   we_i    : write strobe, be_i selects byte lanes
//   waddr_i : write word index, wdata_i write data
//   raddr_i : read word index, rdata_o combinational read data
module ahb_sram_array
  #(parameter int unsigned DEPTH = 256,
    localparam int unsigned AW = $clog2(DEPTH))
  (input  logic          clk_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o);

  logic [31:0] mem_q [DEPTH];

  // Byte-masked write
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder with programmable wait states.
// Optional feature macro: AHB_SLAVE_ERR_EN enables the two-cycle ERROR
// response for oversize, misaligned or out-of-range transfers; without it
// addresses wrap modulo DEPTH and every transfer completes OKAY.
//   hclk, hreset       : clock, async active-high reset
//   hsel, haddr, htrans,
//   hwrite, hsize      : address phase controls
//   hwdata             : write data (data phase)
//   hready             : bus-level ready
//   hrdata, hreadyout,
//   hresp              : registered response to the slave-to-master mux
module ahb_sram_slave
  import ahb_pkg::*;
  #(parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1)
  (input  logic        hclk,
   input  logic        hreset,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic [31:0] hrdata,
   output logic        hreadyout,
   output logic        hresp);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  slv_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic          write_q, write_d;
  logic [2:0]    size_q, size_d;
  logic          hreadyout_q, hreadyout_d;
  logic          hresp_q, hresp_d;
  logic [31:0]   hrdata_q, hrdata_d;

  logic          acc_c;
  logic          we_c;
  logic [3:0]    be_c;
  logic [AW-1:0] rd_idx_c;
  logic [31:0]   mem_rdata_c;
  logic [31:0]   fwd_c;

  // Accept only while this slave is ready and the bus advances
  assign acc_c = hsel && hready && hreadyout_q &&
                 (htrans != HTRANS_IDLE) && (htrans != HTRANS_BUSY);

`ifdef AHB_SLAVE_ERR_EN
  logic illegal_c;
  assign illegal_c = (hsize > HSIZE_WORD) ||
                     ((hsize == HSIZE_HALF) && haddr[0]) ||
                     ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00)) ||
                     (haddr[31:AW+2] != '0);
`else
  logic unused_c;
  assign unused_c = ^haddr[31:AW+2];
`endif

  // Write commits on the edge that ends the DATA cycle
  assign we_c = (state_q == ST_DATA) && write_q;
  assign be_c = byte_en(size_q, addr_q[1:0]);

  // Read index of the transfer about to enter DATA
  assign rd_idx_c = acc_c ? haddr[AW+1:2] : addr_q[AW+1:2];

  ahb_sram_array #(.DEPTH(DEPTH)) u_array (
    .clk_i   (hclk),
    .we_i    (we_c),
    .be_i    (be_c),
    .waddr_i (addr_q[AW+1:2]),
    .wdata_i (hwdata),
    .raddr_i (rd_idx_c),
    .rdata_o (mem_rdata_c)
  );

  // Next-state and response decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    write_d     = write_q;
    size_d      = size_q;
    hreadyout_d = 1'b1;
    hresp_d     = HRESP_OKAY;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d       = cnt_q - CW'(1);
          hreadyout_d = 1'b0;
        end
      end
`ifdef AHB_SLAVE_ERR_EN
      ST_ERR1: begin
        state_d = ST_ERR2;
        hresp_d = HRESP_ERROR;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        if (acc_c) begin
          addr_d  = haddr[AW+1:0];
          write_d = hwrite;
          size_d  = hsize;
`ifdef AHB_SLAVE_ERR_EN
          if (illegal_c) begin
            state_d     = ST_ERR1;
            hreadyout_d = 1'b0;
            hresp_d     = HRESP_ERROR;
          end else
`endif
          if (WAIT_STATES > 0) begin
            state_d     = ST_WAIT;
            cnt_d       = CW'(WAIT_STATES);
            hreadyout_d = 1'b0;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  // Read data for the next DATA cycle; a write committing on the same edge
  // to the same word is merged in lane by lane.
  always_comb begin
    fwd_c = mem_rdata_c;
    for (int i = 0; i < 4; i++) begin
      if (we_c && be_c[i] && (addr_q[AW+1:2] == rd_idx_c)) fwd_c[8*i +: 8] = hwdata[8*i +: 8];
    end
    hrdata_d = ((state_d == ST_DATA) && !write_d) ? fwd_c : 32'h0;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
    end
  end

  assign hrdata    = hrdata_q;
  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;

endmodule
